// File: rtl/uop_pkg.sv
// Shared micro-op field layout and queue entry type for the execute-stage issue queue.
package uop_pkg;

    localparam int UOP_DEC_W = 20;

    localparam int IDX_A_LSB    = 0;
    localparam int IDX_B_LSB    = 3;
    localparam int SEL_INP_BIT  = 6;
    localparam int IDX_DEST_LSB = 8;
    localparam int MEM_W_BIT    = 8;
    localparam int WR_SEL_BIT   = 11;
    localparam int FLAGS_BIT    = 12;
    localparam int MEM_CMD_BIT  = 13;
    localparam int MEM_RQ_BIT   = 14;
    localparam int CARRY_BIT    = 15;
    localparam int ALU_F_LSB    = 16;

    // Entry layout at the default geometry (20-bit uop, 16-bit temp).
    typedef struct packed {
        logic [UOP_DEC_W-1:0] uop;
        logic [15:0]          temp;
        logic                 sched;
        logic                 main;
    } uop_entry_t;

    function automatic logic [2:0] uop_idx3(input logic [UOP_DEC_W-1:0] uop, input int lsb);
        return uop[lsb +: 3];
    endfunction

endpackage

// File: rtl/uop_entry_fifo.sv
// Generic in-order entry storage: wrap-around pointers, occupancy count,
// push/pop with synchronous flush that overrides both.
module uop_entry_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~flush & ~full;
    assign do_pop  = pop & ~flush & ~empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            if (do_push && !do_pop)
                count_next = count_reg + CNT_W'(1);
            else if (!do_push && do_pop)
                count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is cleared on reset so an idle queue presents all-zero fields.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge a_rst) begin
                if (a_rst)
                    mem_reg[gi] <= '0;
                else if (do_push && (wr_ptr_reg == PTR_W'(gi)))
                    mem_reg[gi] <= wr_data;
            end
        end
    endgenerate

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/uop_exec_queue.sv
// In-order micro-op issue queue feeding the execute stage; the head entry drives decode.
// Optional retire/stall counters are built when UOP_EXEC_QUEUE_PERF_EN is defined.
module uop_exec_queue
    import uop_pkg::*;
#(
    parameter int UOP_W  = 20,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              stop,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [UOP_W-1:0]  uop_in,
    input  logic [DATA_W-1:0] temp_a,
    input  logic [DATA_W-1:0] temp_b,
    input  logic              next_sched,
    input  logic              next_main,
    output logic              exec_valid,
    output logic [DATA_W-1:0] t_out,
    output logic [2:0]        idx_a,
    output logic [2:0]        idx_b,
    output logic [2:0]        idx_dest,
    output logic              sel_inp,
    output logic [3:0]        alu_f,
    output logic              carry_mask,
    output logic              reg_wr,
    output logic              flags_w,
    output logic              mar_wr,
    output logic              mem_rq_width,
    output logic              mem_rq_cmd,
    output logic              mem_rq,
    output logic              sched_now,
    output logic              sched_main,
    output logic              main_ex_mem,
`ifdef UOP_EXEC_QUEUE_PERF_EN
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic [CNT_W-1:0]  occupancy
);

    typedef struct packed {
        logic [UOP_W-1:0]  uop;
        logic [DATA_W-1:0] temp;
        logic              sched;
        logic              main;
    } entry_t;

    entry_t                 wr_entry;
    entry_t                 head;
    logic                   full, empty;
    logic                   push, retire;
    logic [UOP_DEC_W-1:0]   hu;

    // Temp operand is resolved at enqueue time so the head needs no select.
    always_comb begin
        wr_entry       = '0;
        wr_entry.uop   = uop_in;
        wr_entry.temp  = next_sched ? temp_b : temp_a;
        wr_entry.sched = next_sched;
        wr_entry.main  = next_main;
    end

    assign in_ready   = ~full & ~flush;
    assign push       = in_valid & in_ready;
    assign exec_valid = ~empty;
    assign retire     = exec_valid & ~stop;

    uop_entry_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .a_rst   (a_rst),
        .push    (push),
        .pop     (retire),
        .flush   (flush),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (occupancy),
        .full    (full),
        .empty   (empty)
    );

    assign hu = head.uop[UOP_DEC_W-1:0];

    // Field outputs always reflect head storage; only strobes are gated.
    assign t_out        = head.temp;
    assign idx_a        = uop_idx3(hu, IDX_A_LSB);
    assign idx_b        = uop_idx3(hu, IDX_B_LSB);
    assign idx_dest     = uop_idx3(hu, IDX_DEST_LSB);
    assign sel_inp      = hu[SEL_INP_BIT];
    assign alu_f        = hu[ALU_F_LSB +: 4];
    assign carry_mask   = ~hu[CARRY_BIT];
    assign mem_rq_cmd   = hu[MEM_CMD_BIT];
    assign sched_now    = head.sched;
    assign sched_main   = head.main;

    assign reg_wr       = ~hu[WR_SEL_BIT] & retire;
    assign flags_w      = hu[FLAGS_BIT] & retire;
    assign mar_wr       = hu[WR_SEL_BIT] & ~hu[10] & ~hu[9] & retire;
    assign mem_rq_width = mar_wr & hu[MEM_W_BIT];
    assign mem_rq       = (hu[MEM_CMD_BIT] | hu[MEM_RQ_BIT]) & retire;
    assign main_ex_mem  = mem_rq & ~(head.main ^ head.sched);

`ifdef UOP_EXEC_QUEUE_PERF_EN
    logic [31:0] retired_cnt_reg;
    logic [31:0] stall_cnt_reg;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            retired_cnt_reg <= '0;
            stall_cnt_reg   <= '0;
        end else begin
            if (retire)
                retired_cnt_reg <= retired_cnt_reg + 32'd1;
            if (exec_valid && stop)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign retired_cnt = retired_cnt_reg;
    assign stall_cnt   = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_uop_exec_queue.sv
// Randomised bench for uop_exec_queue against a queue-based reference model,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/100ps
module tb_uop_exec_queue;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic        clk = 1'b0;
    logic        a_rst, stop, flush, in_valid, next_sched, next_main;
    logic [19:0] uop_in;
    logic [15:0] temp_a, temp_b;
    logic        in_ready, exec_valid, sel_inp, carry_mask, reg_wr, flags_w, mar_wr;
    logic        mem_rq_width, mem_rq_cmd, mem_rq, sched_now, sched_main, main_ex_mem;
    logic [15:0] t_out;
    logic [2:0]  idx_a, idx_b, idx_dest;
    logic [3:0]  alu_f;
    logic [CNT_W-1:0] occupancy;
`ifdef UOP_EXEC_QUEUE_PERF_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    uop_exec_queue #(.UOP_W(20), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .a_rst(a_rst), .stop(stop), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .uop_in(uop_in),
        .temp_a(temp_a), .temp_b(temp_b), .next_sched(next_sched), .next_main(next_main),
        .exec_valid(exec_valid), .t_out(t_out), .idx_a(idx_a), .idx_b(idx_b),
        .idx_dest(idx_dest), .sel_inp(sel_inp), .alu_f(alu_f), .carry_mask(carry_mask),
        .reg_wr(reg_wr), .flags_w(flags_w), .mar_wr(mar_wr), .mem_rq_width(mem_rq_width),
        .mem_rq_cmd(mem_rq_cmd), .mem_rq(mem_rq), .sched_now(sched_now),
        .sched_main(sched_main), .main_ex_mem(main_ex_mem),
`ifdef UOP_EXEC_QUEUE_PERF_EN
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
        .occupancy(occupancy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [19:0] uop;
        logic [15:0] temp;
        logic        sched;
        logic        main;
    } m_t;

    m_t mq[$];
    m_t me;
    int mn;
    int m_ret = 0;
    int m_stall = 0;

    always @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            mq.delete();
            m_ret   = 0;
            m_stall = 0;
        end else begin
            mn = mq.size();
            if (mn != 0 && !stop) m_ret++;
            if (mn != 0 && stop)  m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (mn != 0 && !stop) void'(mq.pop_front());
                if (in_valid && mn < DEPTH) begin
                    me.uop   = uop_in;
                    me.temp  = next_sched ? temp_b : temp_a;
                    me.sched = next_sched;
                    me.main  = next_main;
                    mq.push_back(me);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int          cn;
    m_t          h;
    logic [19:0] u;
    logic        act;
    logic        e_rq;

    always @(negedge clk) begin
        cn = mq.size();
        chk("exec_valid", exec_valid, cn != 0);
        chk("occupancy", occupancy, cn);
        chk("in_ready", in_ready, (cn < DEPTH) && !flush);
        if (cn != 0) begin
            h    = mq[0];
            u    = h.uop;
            act  = !stop;
            e_rq = (u[13] | u[14]) & act;
            chk("t_out", t_out, h.temp);
            chk("idx_a", idx_a, u[2:0]);
            chk("idx_b", idx_b, u[5:3]);
            chk("idx_dest", idx_dest, u[10:8]);
            chk("sel_inp", sel_inp, u[6]);
            chk("alu_f", alu_f, u[19:16]);
            chk("carry_mask", carry_mask, !u[15]);
            chk("mem_rq_cmd", mem_rq_cmd, u[13]);
            chk("sched_now", sched_now, h.sched);
            chk("sched_main", sched_main, h.main);
            chk("reg_wr", reg_wr, !u[11] && act);
            chk("flags_w", flags_w, u[12] && act);
            chk("mar_wr", mar_wr, u[11] && !u[10] && !u[9] && act);
            chk("mem_rq_width", mem_rq_width, u[11] && !u[10] && !u[9] && u[8] && act);
            chk("mem_rq", mem_rq, e_rq);
            chk("main_ex_mem", main_ex_mem, e_rq && (h.main == h.sched));
        end else begin
            chk("idle_strobes", {reg_wr, flags_w, mar_wr, mem_rq_width, mem_rq, main_ex_mem}, 0);
        end
`ifdef UOP_EXEC_QUEUE_PERF_EN
        chk("retired_cnt", retired_cnt, m_ret);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid = 0; stop = 0; flush = 0;
    endtask

    task automatic set_entry(input logic [19:0] u_i, input logic [15:0] ta, input logic [15:0] tb,
                             input logic s, input logic m);
        uop_in = u_i; temp_a = ta; temp_b = tb; next_sched = s; next_main = m;
    endtask

    task automatic do_reset();
        a_rst = 1; step(); step(); a_rst = 0; step();
    endtask

    initial begin
        a_rst = 1; idle();
        set_entry(20'h0, 16'h0, 16'h0, 0, 0);
        step(); step(); a_rst = 0; step();

        // Reset state
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_t_out", t_out, 0);
        chk("rst_alu_f", alu_f, 0);
        chk("rst_carry_mask", carry_mask, 1);
        chk("rst_reg_wr", reg_wr, 0);

        // Single push: uop 5_0823 -> alu_f 5, idx_a 3, bit11=1 bit10=0 bit9=0, no mem request
        set_entry(20'h50823, 16'h1234, 16'hFFFF, 0, 0);
        in_valid = 1; step(); in_valid = 0;
        chk("t1_exec_valid", exec_valid, 1);
        chk("t1_t_out", t_out, 16'h1234);
        chk("t1_alu_f", alu_f, 4'h5);
        chk("t1_idx_a", idx_a, 3);
        chk("t1_idx_b", idx_b, 4);
        chk("t1_reg_wr", reg_wr, 0);
        chk("t1_mar_wr", mar_wr, 1);
        chk("t1_mem_rq", mem_rq, 0);
        step();

        // Three pushes under stop: only two land
        stop = 1; in_valid = 1;
        set_entry(20'h00001, 16'h1111, 16'h0, 0, 0); step();
        set_entry(20'h00002, 16'h2222, 16'h0, 0, 0); step();
        chk("t2_in_ready_full", in_ready, 0);
        set_entry(20'h00003, 16'h3333, 16'h0, 0, 0); step();
        chk("t2_occupancy", occupancy, 2);
        in_valid = 0; stop = 0;
        chk("t2_first", t_out, 16'h1111);
        step();
        chk("t2_second", t_out, 16'h2222);
        chk("t2_occ_after", occupancy, 1);
        step();
        chk("t2_drained", exec_valid, 0);

        // Sched/main context on a memory uop
        set_entry(20'h02000, 16'hAAAA, 16'hBEEF, 1, 1);
        in_valid = 1; step();
        set_entry(20'h02000, 16'hAAAA, 16'hBEEF, 1, 0);
        chk("t3_t_out", t_out, 16'hBEEF);
        chk("t3_mem_rq", mem_rq, 1);
        chk("t3_main_ex_mem", main_ex_mem, 1);
        step(); in_valid = 0;
        chk("t3b_mem_rq", mem_rq, 1);
        chk("t3b_main_ex_mem", main_ex_mem, 0);
        step();

        // Flush of a full queue while offering an entry
        stop = 1; in_valid = 1;
        set_entry(20'h0F0F0, 16'h5555, 16'h6666, 0, 1); step(); step();
        chk("t4_full", occupancy, 2);
        flush = 1; step(); flush = 0; in_valid = 0;
        chk("t4_occupancy", occupancy, 0);
        chk("t4_exec_valid", exec_valid, 0);
        step();

        // Asynchronous reset between edges with two entries held
        stop = 1; in_valid = 1;
        set_entry(20'h07000, 16'h7777, 16'h8888, 0, 0); step(); step();
        in_valid = 0; stop = 0; #1;
        chk("t5_pre_flags_w", flags_w, 1);
        a_rst = 1; #1;
        chk("t5_exec_valid", exec_valid, 0);
        chk("t5_occupancy", occupancy, 0);
        chk("t5_strobes", {reg_wr, flags_w, mar_wr, mem_rq}, 0);
        step(); a_rst = 0; step();

`ifdef UOP_EXEC_QUEUE_PERF_EN
        do_reset();
        set_entry(20'h00100, 16'h0001, 16'h0, 0, 0);
        in_valid = 1; step();
        in_valid = 0; stop = 1; step(); step(); step();
        stop = 0; in_valid = 1;
        repeat (4) step();
        in_valid = 0; step();
        chk("perf_retired", retired_cnt, 5);
        chk("perf_stall", stall_cnt, 3);
        flush = 1; step(); flush = 0;
        chk("perf_retired_flush", retired_cnt, 5);
        chk("perf_stall_flush", stall_cnt, 3);
`endif

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom % 4) != 0;
            stop     = ($urandom % 10) < 3;
            flush    = ($urandom % 32) == 0;
            set_entry(20'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            if (($urandom % 400) == 0) begin
                a_rst = 1; step(); a_rst = 0;
            end else begin
                step();
            end
        end
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
